user_ip_apb_bridge: RTL
=======================

# user_ip_apb_bridge

Registered APB4 bridge between the SoC peripheral bus and the user IP slots. Each slot is one `user_ip_design` instance. The bridge decodes the upstream address into a slot index and replays the transfer on that slot's private APB4 port. It bounds every access with a watchdog, so a hung or missing user IP returns an error instead of stalling the bus. It sits directly upstream of the user IP slots, and its downstream ports feed their `apb4_if.slave` ports.

## Interface

Parameters:
- `SLOT_NUM`, default 4: number of user IP slots, range 1..16.
- `TIMEOUT`, default 255: maximum ACCESS cycles allowed before abort, range 1..255.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1: bus clock.
- `rst_i`  in  1: asynchronous, active-high reset.
- `apb`  modport `apb4_if.slave`: upstream port. Fields used: `paddr[31:0]`, `pwrite`, `psel`, `penable`, `pwdata[31:0]`, `pstrb[3:0]`, `prdata[31:0]`, `pready`, `pslverr`.
- `slv[SLOT_NUM]`  modport `apb4_if.master`: one downstream port per slot.
- `timeout_o`  out  1: one-cycle pulse when an access is aborted by the watchdog.
- `err_slot_o`  out  4: index of the slot that last timed out or was addressed out of range. Sticky until the next error.

## Operation

- Decode: slot index = `paddr[11:8]`; slot-local offset = `paddr[7:0]`. Downstream `paddr` = `{24'd0, paddr[7:0]}`.
- FSM states:
  - IDLE:
    - Capture the request when upstream `psel && penable` is high.
    - Latch addr, wdata, strb and write.
    - Valid slot (index < `SLOT_NUM`) -> SETUP. Invalid slot -> RESP with error.
  - SETUP: selected slot `psel`=1, `penable`=0. Always -> ACCESS.
  - ACCESS:
    - Selected slot `psel`=1, `penable`=1; the watchdog counts.
    - Slot `pready`=1 -> RESP. Latch its `prdata` (reads only; writes latch 0) and its `pslverr`.
    - Count reaches `TIMEOUT` with no `pready` -> RESP with `pslverr`=1, `prdata`=0, `timeout_o` pulse, `err_slot_o` updated.
  - RESP: upstream `pready`=1 for exactly one cycle, with registered `prdata`/`pslverr`. Always -> IDLE.
- Non-selected slots always see `psel`=`penable`=0. All downstream `pwdata`/`pstrb`/`pwrite` are driven from the latched values.
- Upstream `pready` is 0 in every state except RESP; upstream wait states are inserted automatically.
- Out-of-range slot: no downstream activity; `pslverr`=1, `prdata`=0, `err_slot_o` = decoded index, no `timeout_o`.
- Slot `pready` on the same cycle the count reaches `TIMEOUT`: `pready` wins; normal response; no `timeout_o`.
- Upstream `psel` dropped mid-transfer (protocol violation): ignored; the transfer runs to RESP.
- A new upstream request is captured only in IDLE. The cycle after RESP is IDLE, so there are no back-to-back captures from RESP.

## Timing

- Reset values: FSM=IDLE, all downstream `psel`/`penable`=0, upstream `pready`=0, `pslverr`=0, `prdata`=0, `timeout_o`=0, `err_slot_o`=0, watchdog=0.
- Reset asserted mid-transfer: immediate return to reset values; downstream `psel` drops asynchronously.
- Zero-wait slot, upstream access phase first seen at edge t:
  - SETUP at t+1.
  - ACCESS at t+2.
  - Upstream `pready` high in cycle t+3.
  - Total: 3 upstream wait cycles.
- Slot with W wait states: upstream `pready` at t+3+W.
- Timeout: ACCESS lasts `TIMEOUT` cycles; `pready`/`pslverr` in cycle t+2+`TIMEOUT`; `timeout_o` is high in that same cycle.
- Out-of-range: upstream `pready` at t+1.
- Watchdog: 8-bit counter, cleared on SETUP entry, increments each ACCESS cycle without `pready`, no wrap.

## Structure

- Shared package `user_ip_pkg`:
  - FSM enum: IDLE, SETUP, ACCESS, RESP.
  - `SLOT_IDX_LSB`=8, `SLOT_IDX_W`=4, `SLOT_OFS_W`=8.
  - `APB_ERR_RDATA`=32'h0.
- One sub-module, `user_ip_apb_wdt`:
  - Inputs: `clr`, `en`, `hit`.
  - Terminal-count output compared against `TIMEOUT`.
  - Reused by future bus stages.

## Test plan

- Read slot 0, offset 0x00, zero-wait slot returning 32'h0000_00FF -> upstream `prdata`=32'h0000_00FF, `pslverr`=0, `pready` 3 cycles after the access phase.
- Write 32'hA5A5_A5A5 to slot 2, offset 0x04, `pstrb`=4'hF -> only `slv[2]` sees `psel`; its `pwdata`/`pstrb`/`paddr`=0x04 match; other slots stay idle.
- Slot 1 holds `pready` low forever, `TIMEOUT`=8 -> upstream `pslverr`=1, `prdata`=0, `timeout_o` 1-cycle pulse, `err_slot_o`=1, slot 1 `psel` deasserted.
- `paddr`=0x0000_0F00 with `SLOT_NUM`=4 -> `pready` next cycle, `pslverr`=1, `err_slot_o`=15, no downstream `psel`.
- Slot asserts `pready` exactly at watchdog terminal count -> normal response, `pslverr`=0, no `timeout_o`.
- Assert `rst_i` during ACCESS -> all outputs return to reset values; the next read of slot 0 completes normally.

Source files
------------

// File: rtl/user_ip_pkg.sv
// Shared definitions for the user IP bus stages: FSM states, address-decode
// field positions and the data returned on an aborted or rejected access.
package user_ip_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } bridge_state_e;

    localparam int SLOT_IDX_LSB = 8;
    localparam int SLOT_IDX_W   = 4;
    localparam int SLOT_OFS_W   = 8;

    localparam logic [31:0] APB_ERR_RDATA = 32'h0;

    function automatic logic [SLOT_IDX_W-1:0] slot_index(input logic [31:0] addr);
        return addr[SLOT_IDX_LSB +: SLOT_IDX_W];
    endfunction

endpackage

// File: rtl/apb4_if.sv
// APB4 signal bundle used both upstream of the bridge and on every user IP slot.
interface apb4_if;
    logic [31:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, pwrite, psel, penable, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/user_ip_apb_wdt.sv
// Access watchdog: counts stalled cycles and flags the cycle whose count would
// reach TIMEOUT, unless the target answers in that same cycle.
module user_ip_apb_wdt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    input  logic hit,
    output logic expired
);

    logic [7:0] count;

    // Saturating counter so an unbounded stall never wraps back to a small value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en && !hit && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign expired = en && !hit && (({1'b0, count} + 9'd1) == 9'(TIMEOUT));

endmodule

// File: rtl/user_ip_apb_bridge.sv
// Registered APB4 bridge: decodes the upstream address into a user IP slot and
// replays the transfer on that slot's private port, aborting hung accesses.
module user_ip_apb_bridge
    import user_ip_pkg::*;
#(
    parameter int SLOT_NUM = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    apb4_if.slave      apb,
    apb4_if.master     slv [SLOT_NUM],
    output logic       timeout_o,
    output logic [3:0] err_slot_o
);

    bridge_state_e state_q;

    logic [SLOT_IDX_W-1:0] slot_q;
    logic [SLOT_OFS_W-1:0] ofs_q;
    logic [31:0]           wdata_q;
    logic [3:0]            strb_q;
    logic                  write_q;
    logic                  dn_psel_q;
    logic                  dn_penable_q;
    logic                  up_pready_q;
    logic                  up_pslverr_q;
    logic [31:0]           up_prdata_q;

    logic [SLOT_IDX_W-1:0] req_slot;
    logic                  req_in_range;
    logic                  wdt_clr;
    logic                  wdt_expired;

    // Slot responses gathered into full 16-entry tables so any index is legal.
    logic [15:0] slot_ready;
    logic [15:0] slot_err;
    logic [31:0] slot_rdata [16];
    logic        sel_ready;
    logic        sel_err;
    logic [31:0] sel_rdata;

    assign req_slot     = slot_index(apb.paddr);
    assign req_in_range = int'(req_slot) < SLOT_NUM;
    assign sel_ready    = slot_ready[slot_q];
    assign sel_err      = slot_err[slot_q];
    assign sel_rdata    = slot_rdata[slot_q];

    assign apb.pready  = up_pready_q;
    assign apb.pslverr = up_pslverr_q;
    assign apb.prdata  = up_prdata_q;

    for (genvar g = 0; g < 16; g++) begin : g_slot
        if (g < SLOT_NUM) begin : g_used
            assign slv[g].psel    = dn_psel_q && (slot_q == SLOT_IDX_W'(g));
            assign slv[g].penable = dn_penable_q && (slot_q == SLOT_IDX_W'(g));
            assign slv[g].paddr   = {{(32-SLOT_OFS_W){1'b0}}, ofs_q};
            assign slv[g].pwrite  = write_q;
            assign slv[g].pwdata  = wdata_q;
            assign slv[g].pstrb   = strb_q;
            assign slot_ready[g]  = slv[g].pready;
            assign slot_err[g]    = slv[g].pslverr;
            assign slot_rdata[g]  = slv[g].prdata;
        end else begin : g_unused
            assign slot_ready[g] = 1'b0;
            assign slot_err[g]   = 1'b0;
            assign slot_rdata[g] = 32'h0;
        end
    end

    assign wdt_clr = (state_q == IDLE) && apb.psel && apb.penable && req_in_range;

    user_ip_apb_wdt #(
        .TIMEOUT(TIMEOUT)
    ) u_wdt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (wdt_clr),
        .en     (state_q == ACCESS),
        .hit    (sel_ready),
        .expired(wdt_expired)
    );

    // Upstream psel is only looked at in IDLE, so a master dropping it mid-transfer is ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            ofs_q        <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            write_q      <= 1'b0;
            dn_psel_q    <= 1'b0;
            dn_penable_q <= 1'b0;
            up_pready_q  <= 1'b0;
            up_pslverr_q <= 1'b0;
            up_prdata_q  <= '0;
            timeout_o    <= 1'b0;
            err_slot_o   <= '0;
        end else begin
            timeout_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (apb.psel && apb.penable) begin
                        slot_q  <= req_slot;
                        ofs_q   <= apb.paddr[SLOT_OFS_W-1:0];
                        wdata_q <= apb.pwdata;
                        strb_q  <= apb.pstrb;
                        write_q <= apb.pwrite;
                        if (req_in_range) begin
                            state_q   <= SETUP;
                            dn_psel_q <= 1'b1;
                        end else begin
                            state_q      <= RESP;
                            up_pready_q  <= 1'b1;
                            up_pslverr_q <= 1'b1;
                            up_prdata_q  <= APB_ERR_RDATA;
                            err_slot_o   <= req_slot;
                        end
                    end
                end
                SETUP: begin
                    state_q      <= ACCESS;
                    dn_penable_q <= 1'b1;
                end
                ACCESS: begin
                    // A slot answering on the terminal-count cycle still wins over the watchdog.
                    if (sel_ready) begin
                        state_q      <= RESP;
                        dn_psel_q    <= 1'b0;
                        dn_penable_q <= 1'b0;
                        up_pready_q  <= 1'b1;
                        up_pslverr_q <= sel_err;
                        up_prdata_q  <= write_q ? 32'h0 : sel_rdata;
                    end else if (wdt_expired) begin
                        state_q      <= RESP;
                        dn_psel_q    <= 1'b0;
                        dn_penable_q <= 1'b0;
                        up_pready_q  <= 1'b1;
                        up_pslverr_q <= 1'b1;
                        up_prdata_q  <= APB_ERR_RDATA;
                        timeout_o    <= 1'b1;
                        err_slot_o   <= slot_q;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    up_pready_q  <= 1'b0;
                    up_pslverr_q <= 1'b0;
                    up_prdata_q  <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
